bcd_display_converter: RTL and testbench

- Sequential binary-to-BCD converter between the ALU result output and the seven-segment digit decoder.
- Uses double-dabble (shift-and-add-3), one bit per clock.
- Converts automatically whenever the input value changes.
- Holds the last completed decimal digits stable on its outputs, so the display never shows partial results.

---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd_digit_adjust.sv | 27 ++
 rtl/bcd_display_converter.sv | 167 ++++++++++++++++
 tb/tb_bcd_display_converter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the BCD display converter.
//                Holds the converter state encoding and the double-dabble
//                per-digit adjust constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one BCD digit
    localparam int BCD_DIGIT_W = 4;

    // A digit at or above this value would exceed 9 after the next shift
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESHOLD = 4'd5;

    // Correction added to such a digit before shifting
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD = 4'd3;

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Combinational double-dabble digit correction. Adds 3 to a
//                BCD digit whose value is 5 or more, otherwise passes it
//                through unchanged.
//  Ports       : digit_in  - 4-bit BCD digit before correction
//                digit_out - 4-bit BCD digit after correction
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        if (digit_in >= BCD_ADJ_THRESHOLD) begin
            digit_out = digit_in + BCD_ADJ_ADD;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/bcd_display_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_converter
//  Description : Sequential binary-to-BCD converter (double dabble, one bit
//                per clock). Reconverts whenever the input value differs
//                from the last latched value or on a start pulse, and keeps
//                the last completed digits stable on bcd.
//  Ports       : clock    - system clock, rising edge
//                reset    - synchronous active-high reset
//                value    - binary value to display
//                start    - forces reconversion of the current value
//                bcd      - registered BCD digits, [3:0] = ones
//                negative - sign flag (SIGNED_DISPLAY_EN only, else 0)
//                busy     - conversion in progress
//                valid    - one-cycle pulse when bcd updates
//  Options     : SIGNED_DISPLAY_EN - treat value as two's complement and
//                display sign + magnitude
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_converter
    import display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
)
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           value,
    input  logic                        start,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        negative,
    output logic                        busy,
    output logic                        valid
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   latched;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   operand_load;
    logic [SCR_W-1:0]    scratch;
    logic [SCR_W-1:0]    adjusted;
    logic [SCR_W+DATA_W-1:0] shifted;
    logic [CNT_W-1:0]    count;
    logic                trigger;
    logic                last_shift;

    // start and a value change in the same cycle collapse into one trigger
    assign trigger    = (value != latched) || start;
    assign last_shift = (count == LAST_BIT);

    // ------------------------------------------------------------------
    // Per-digit add-3 correction ahead of each shift
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (scratch [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adjusted[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected scratch and operand shift left together as one register
    assign shifted = {adjusted, operand} << 1;

    // ------------------------------------------------------------------
    // Optional sign handling
    // ------------------------------------------------------------------
`ifdef SIGNED_DISPLAY_EN
    logic neg_pending;

    // Most negative input negates to itself, which reads correctly as an
    // unsigned magnitude
    assign operand_load = value[DATA_W-1] ? (~value + 1'b1) : value;

    always_ff @(posedge clock) begin
        if (reset) begin
            neg_pending <= 1'b0;
            negative    <= 1'b0;
        end else begin
            if (state == IDLE && trigger) begin
                neg_pending <= value[DATA_W-1];
            end
            // Sign updates only together with the digits
            if (state == DONE) begin
                negative <= neg_pending;
            end
        end
    end
`else
    assign operand_load = value;
    assign negative     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger)    state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            latched <= '0;
            operand <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        latched <= value;
                        operand <= operand_load;
                        scratch <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= shifted[SCR_W+DATA_W-1:DATA_W];
                    operand <= shifted[DATA_W-1:0];
                    if (!last_shift) begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    bcd   <= scratch;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : bcd_display_converter
`default_nettype wire

// File: tb/tb_bcd_display_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_converter
//  Description : Self-checking bench for bcd_display_converter. A cycle-level
//                behavioural model (decimal arithmetic plus a countdown of the
//                conversion latency) is compared against the DUT every cycle,
//                and directed scenarios pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_converter;

    localparam int DATA_W = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = DATA_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] value;
    logic              start;
    logic [4*DIGITS-1:0] bcd;
    logic              negative;
    logic              busy;
    logic              valid;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    bcd_display_converter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clock    (clk),
        .reset    (reset),
        .value    (value),
        .start    (start),
        .bcd      (bcd),
        .negative (negative),
        .busy     (busy),
        .valid    (valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Decimal digits of an integer, packed as BCD
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int magnitude(input logic [DATA_W-1:0] v);
`ifdef SIGNED_DISPLAY_EN
        if (v[DATA_W-1]) return (1 << DATA_W) - int'(v);
`endif
        return int'(v);
    endfunction

    function automatic logic sign_of(input logic [DATA_W-1:0] v);
`ifdef SIGNED_DISPLAY_EN
        return v[DATA_W-1];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: a conversion occupies LAT cycles after the
    // trigger edge, then the display shows the decimal value of the
    // latched input.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   m_lat   = '0;
    int                  m_left  = 0;
    logic [4*DIGITS-1:0] m_bcd   = '0;
    logic                m_neg   = 1'b0;
    logic                m_busy  = 1'b0;
    logic                m_valid = 1'b0;
    logic                started = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (reset) begin
            m_lat = '0; m_left = 0; m_bcd = '0; m_neg = 1'b0; m_busy = 1'b0;
            started = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_bcd   = to_bcd(magnitude(m_lat));
                m_neg   = sign_of(m_lat);
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
        end else if (value != m_lat || start) begin
            m_lat  = value;
            m_left = LAT;
            m_busy = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("model_bcd",      32'(bcd),      32'(m_bcd));
            chk("model_valid",    32'(valid),    32'(m_valid));
            chk("model_busy",     32'(busy),     32'(m_busy));
            chk("model_negative", 32'(negative), 32'(m_neg));
        end
    end

    // Bounded wait for the next valid pulse; returns cycles waited
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!valid && cyc < 40);
        chk("valid_seen", 32'(valid), 32'd1);
    endtask

    task automatic drive_and_convert(input logic [DATA_W-1:0] v, output int cyc);
        @(negedge clk); value = v;
        wait_valid(cyc);
    endtask

    int cyc;
    int pulses;

    initial begin
        reset = 1'b1; value = 8'hFF; start = 1'b0;

        // Reset held with a nonzero input
        repeat (2) @(negedge clk);
        chk("reset_bcd",  32'(bcd),  32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_busy", 32'(busy), 32'd1);
        wait_valid(cyc);
        chk("reset_latency", 32'(cyc + 1), 32'd10);
        chk("bcd_255", 32'(bcd), 32'h255);

        // 0x00 then 0x64: exactly one valid pulse, then 100
        drive_and_convert(8'h00, cyc);
        chk("bcd_000", 32'(bcd), 32'h000);
        @(negedge clk); value = 8'h64;
        @(posedge clk); #1;
        chk("busy_rise", 32'(busy), 32'd1);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        chk("one_valid", 32'(pulses), 32'd1);
        chk("bcd_100", 32'(bcd), 32'h100);

        // Value change mid-conversion is picked up afterwards
        drive_and_convert(8'd200, cyc);
        chk("bcd_200", 32'(bcd), 32'h200);
        @(negedge clk); value = 8'd100;
        repeat (4) @(negedge clk);
        value = 8'd42;
        wait_valid(cyc);
        chk("first_100", 32'(bcd), 32'h100);
        wait_valid(cyc);
        chk("second_042", 32'(bcd), 32'h042);

        // start with unchanged value forces a reconversion
        drive_and_convert(8'h07, cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        wait_valid(cyc);
        chk("bcd_007", 32'(bcd), 32'h007);

        // Reset in the middle of a conversion
        @(negedge clk); value = 8'h99;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_bcd",   32'(bcd),   32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_busy",  32'(busy),  32'h0);
        @(negedge clk); reset = 1'b0;
        wait_valid(cyc);
        chk("bcd_153", 32'(bcd), 32'h153);

        // Sign-related patterns
        drive_and_convert(8'h80, cyc);
`ifdef SIGNED_DISPLAY_EN
        chk("s80_bcd", 32'(bcd), 32'h128); chk("s80_neg", 32'(negative), 32'd1);
        drive_and_convert(8'hFF, cyc);
        chk("sFF_bcd", 32'(bcd), 32'h001); chk("sFF_neg", 32'(negative), 32'd1);
`else
        chk("u80_bcd", 32'(bcd), 32'h128); chk("u80_neg", 32'(negative), 32'd0);
        drive_and_convert(8'hFF, cyc);
        chk("uFF_bcd", 32'(bcd), 32'h255); chk("uFF_neg", 32'(negative), 32'd0);
`endif
        drive_and_convert(8'h7F, cyc);
        chk("s7F_bcd", 32'(bcd), 32'h127); chk("s7F_neg", 32'(negative), 32'd0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(15) == 0);
            if ($urandom_range(5) == 0) value = DATA_W'($urandom);
            reset = ($urandom_range(150) == 0);
        end
        @(negedge clk); reset = 1'b0; start = 1'b0;
        repeat (2 * LAT + 4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bcd_display_converter
`default_nettype wire
